// File: rtl/sector_pulse_generator_if.sv
// -----------------------------------------------------------------------------
// sector_pulse_generator_if
//
// Purpose:
//   Bundles the rotational-position signals exchanged between the sector pulse
//   generator and the stages that consume it (seek, read/write, bus driver).
//
// Signals:
//   BUS_SECTOR_DRIVE_L  real drive sector pulse (async, active low), into generator
//   clkenbl_sector      one-clock blip at each sector boundary
//   Sector_Address      current sector number, 0..NUM_SECTORS-1
//   BUS_SECTOR_EMUL_L   emulated bus sector pulse, active low
//   sector_running      high while the spindle emulation is in RUN
//
// Modports:
//   master  the generator: drives position outputs, samples the drive pulse
//   slave   a consumer: samples position outputs, may source the drive pulse
// -----------------------------------------------------------------------------
interface sector_pulse_generator_if;
    logic       BUS_SECTOR_DRIVE_L;
    logic       clkenbl_sector;
    logic [2:0] Sector_Address;
    logic       BUS_SECTOR_EMUL_L;
    logic       sector_running;

    modport master (
        input  BUS_SECTOR_DRIVE_L,
        output clkenbl_sector,
        output Sector_Address,
        output BUS_SECTOR_EMUL_L,
        output sector_running
    );

    modport slave (
        output BUS_SECTOR_DRIVE_L,
        input  clkenbl_sector,
        input  Sector_Address,
        input  BUS_SECTOR_EMUL_L,
        input  sector_running
    );
endinterface

// File: rtl/sector_pulse_generator.sv
// -----------------------------------------------------------------------------
// sector_pulse_generator
//
// Purpose:
//   Emulates 2310 spindle rotation timing. The 1 usec clock enable is divided
//   into NUM_SECTORS logical sectors per revolution. At every sector boundary
//   the block emits a one-clock clkenbl_sector blip, advances Sector_Address
//   and starts an active-low bus sector pulse of PULSE_USEC microseconds
//   (visible only while the drive is selected and ready). It is the sole
//   source of rotational position for the seek and read/write stages.
//
// Ports:
//   clock            in   master clock (40 MHz)
//   reset_n          in   asynchronous active-low reset
//   clkenbl_1usec    in   1 usec clock enable from the timing generator
//   Cart_Ready       in   virtual cartridge loaded (spindle running)
//   Selected_Ready   in   drive selected, image loaded and no fault
//   real_drive       in   real (1) or virtual (0) drive mode
//   bus              sector_pulse_generator_if.master
//                      BUS_SECTOR_DRIVE_L in, clkenbl_sector / Sector_Address /
//                      BUS_SECTOR_EMUL_L / sector_running out
//
// Configuration:
//   SECTOR_RESYNC_EN  when defined, BUS_SECTOR_DRIVE_L is synchronised and, in
//                     RUN with real_drive=1, its falling edges replace the
//                     internal sector wrap. When undefined the drive pulse is
//                     ignored and timing is purely internal in both modes.
// -----------------------------------------------------------------------------
module sector_pulse_generator #(
    parameter int unsigned NUM_SECTORS = 8,      // power of 2, <= 8
    parameter int unsigned SECTOR_USEC = 5000,
    parameter int unsigned PULSE_USEC  = 165,
    parameter int unsigned SPINUP_USEC = 20000,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           clkenbl_1usec,
    input  logic                           Cart_Ready,
    input  logic                           Selected_Ready,
    input  logic                           real_drive,
    sector_pulse_generator_if.master       bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SPINUP = 2'd1,
        RUN    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] SPINUP_LAST = CNT_W'(SPINUP_USEC - 1);
    localparam logic [CNT_W-1:0] SECTOR_LAST = CNT_W'(SECTOR_USEC - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD  = CNT_W'(PULSE_USEC);
    localparam logic [2:0]       SECTOR_MASK = 3'(NUM_SECTORS - 1);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   usec_cnt_q;
    logic [CNT_W-1:0]   usec_cnt_d;
    logic [CNT_W-1:0]   pulse_cnt_q;
    logic [2:0]         sector_q;
    logic               clkenbl_sector_q;
    logic               bus_sector_emul_l_q;

    logic               boundary;        // sector boundary decided this cycle
    logic               first_boundary;  // boundary that ends spin-up
    logic               resync_mode;     // drive pulse owns the boundary timing
    logic               drive_fall;      // synchronised falling edge of drive pulse

    // -------------------------------------------------------------------------
    // Real drive sector pulse resynchronisation
    // -------------------------------------------------------------------------
`ifdef SECTOR_RESYNC_EN
    logic drive_l_p0;
    logic drive_l_p1;
    logic drive_l_p2;

    // Three flops: p0/p1 resolve metastability, p1/p2 form the edge detector.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            drive_l_p0 <= 1'b0;
            drive_l_p1 <= 1'b0;
            drive_l_p2 <= 1'b0;
        end else begin
            drive_l_p0 <= bus.BUS_SECTOR_DRIVE_L;
            drive_l_p1 <= drive_l_p0;
            drive_l_p2 <= drive_l_p1;
        end
    end

    assign drive_fall  = drive_l_p2 & ~drive_l_p1;
    assign resync_mode = real_drive && (state_q == RUN);
`else
    logic unused_resync_inputs;

    assign drive_fall           = 1'b0;
    assign resync_mode          = 1'b0;
    assign unused_resync_inputs = &{1'b0, bus.BUS_SECTOR_DRIVE_L, real_drive};
`endif

    // -------------------------------------------------------------------------
    // Rotation state machine: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            usec_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            usec_cnt_q <= usec_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Rotation state machine: next state, usec counter and boundary decision
    // -------------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        usec_cnt_d     = usec_cnt_q;
        boundary       = 1'b0;
        first_boundary = 1'b0;

        if (!Cart_Ready) begin
            // Spindle stopped: everything collapses back to IDLE next clock.
            state_d    = IDLE;
            usec_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    usec_cnt_d = '0;
                    state_d    = SPINUP;
                end

                SPINUP: begin
                    if (clkenbl_1usec) begin
                        if (usec_cnt_q >= SPINUP_LAST) begin
                            state_d        = RUN;
                            usec_cnt_d     = '0;
                            boundary       = 1'b1;
                            first_boundary = 1'b1;
                        end else begin
                            usec_cnt_d = usec_cnt_q + CNT_W'(1);
                        end
                    end
                end

                RUN: begin
                    if (resync_mode) begin
                        // The drive edge is the only boundary; the internal
                        // count just parks at its terminal value meanwhile, so
                        // an edge on a terminal-count cycle still gives one blip.
                        if (drive_fall) begin
                            usec_cnt_d = '0;
                            boundary   = 1'b1;
                        end else if (clkenbl_1usec && (usec_cnt_q < SECTOR_LAST)) begin
                            usec_cnt_d = usec_cnt_q + CNT_W'(1);
                        end
                    end else if (clkenbl_1usec) begin
                        if (usec_cnt_q >= SECTOR_LAST) begin
                            usec_cnt_d = '0;
                            boundary   = 1'b1;
                        end else begin
                            usec_cnt_d = usec_cnt_q + CNT_W'(1);
                        end
                    end
                end

                default: begin
                    // Illegal encoding: recover to IDLE.
                    state_d    = IDLE;
                    usec_cnt_d = '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Boundary outputs: sector number and one-clock blip
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sector_q         <= 3'd0;
            clkenbl_sector_q <= 1'b0;
        end else begin
            clkenbl_sector_q <= boundary;
            if (boundary) begin
                sector_q <= first_boundary ? 3'd0 : ((sector_q + 3'd1) & SECTOR_MASK);
            end else if (state_d == IDLE) begin
                sector_q <= 3'd0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Bus sector pulse: width counter, then registered active-low output
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pulse_cnt_q <= '0;
        end else if (!Cart_Ready) begin
            pulse_cnt_q <= '0;
        end else if (boundary) begin
            pulse_cnt_q <= PULSE_LOAD;
        end else if (clkenbl_1usec && (pulse_cnt_q != '0)) begin
            pulse_cnt_q <= pulse_cnt_q - CNT_W'(1);
        end
    end

    // Deselecting only masks the pulse; the counter keeps running so the
    // pulse reappears correctly aligned if the drive is reselected mid-pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus_sector_emul_l_q <= 1'b1;
        end else if (!Cart_Ready) begin
            bus_sector_emul_l_q <= 1'b1;
        end else begin
            bus_sector_emul_l_q <= ~((pulse_cnt_q != '0) && Selected_Ready);
        end
    end

    assign bus.clkenbl_sector    = clkenbl_sector_q;
    assign bus.Sector_Address    = sector_q;
    assign bus.BUS_SECTOR_EMUL_L = bus_sector_emul_l_q;
    assign bus.sector_running    = (state_q == RUN);

endmodule
